// File: rtl/rv_pkg.sv
// Shared RV execute-stage types: control bundle, ALU and M-extension
// encodings, forward selects and MDU states.
package rv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    alu_op_t    ALUControl;
    logic       ALUSrc;
    logic       SrcAsrc;
    logic [2:0] funct3;
    logic       jumpReg;
    logic       MulDiv;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_stage_mdu_if.sv
// Decode-to-execute bundle: control plus operands and register indices.
interface ex_stage_mdu_if #(
  parameter int XLEN = 32
);
  import rv_pkg::*;

  ex_ctrl_t          CtrlD;
  logic [XLEN-1:0]   RD1D;
  logic [XLEN-1:0]   RD2D;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic [XLEN-1:0]   ImmExtD;
  logic [4:0]        Rs1D;
  logic [4:0]        Rs2D;
  logic [4:0]        RdD;

  modport master (
    output CtrlD, RD1D, RD2D, PCD,
    output PCPlus4D, ImmExtD,
    output Rs1D, Rs2D, RdD
  );

  modport slave (
    input CtrlD, RD1D, RD2D, PCD,
    input PCPlus4D, ImmExtD,
    input Rs1D, Rs2D, RdD
  );

endinterface

// File: rtl/mdu_iter.sv
// Iterative M-extension unit: shift-add multiply and restoring divide
// on operand magnitudes, BPC bits per cycle, sign fixed on entry to DONE.
module mdu_iter
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic            hold,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);

  md_state_e         state, state_n;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   hi, lo, m;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [XLEN:0]     t;
  md_op_e            op_q;
  logic              neg_a, neg_b, bzero;
  logic              na, nb, last;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q, r, fix;

  assign na = a[XLEN-1] &
    (op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign nb = b[XLEN-1] &
    (op inside {MD_MULH, MD_DIV, MD_REM});
  assign last = cnt == CW'(N - 1);
  assign done = state == MD_DONE;

  always_comb begin
    hi_n = hi;
    lo_n = lo;
    t    = '0;
    for (int i = 0; i < BPC; i++) begin
      if (op_q[2]) begin
        t    = {hi_n, lo_n[XLEN-1]};
        lo_n = {lo_n[XLEN-2:0], 1'b0};
        if (t >= {1'b0, m}) begin
          t       = t - {1'b0, m};
          lo_n[0] = 1'b1;
        end
        hi_n = t[XLEN-1:0];
      end else begin
        t = {1'b0, hi_n} + (lo_n[0] ? {1'b0, m} : '0);
        {hi_n, lo_n} = {t, lo_n[XLEN-1:1]};
      end
    end
  end

  // Divide-by-zero remainder falls out of the divider as the dividend.
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_a ^ neg_b) prod = -prod;
    q = (neg_a ^ neg_b) ? -lo_n : lo_n;
    if (bzero) q = '1;
    r = neg_a ? -hi_n : hi_n;
    case (op_q)
      MD_MUL:                        fix = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix = q;
      default:                       fix = r;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MD_IDLE: if (start) state_n = MD_BUSY;
      MD_BUSY: if (last)  state_n = MD_DONE;
      MD_DONE: if (!hold) state_n = MD_IDLE;
      default:            state_n = MD_IDLE;
    endcase
    if (flush) state_n = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      op_q   <= MD_MUL;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      bzero  <= 1'b0;
      result <= '0;
    end else if (state == MD_IDLE && start) begin
      cnt   <= '0;
      op_q  <= op;
      neg_a <= na;
      neg_b <= nb;
      bzero <= b == '0;
      hi    <= '0;
      lo    <= na ? -a : a;
      m     <= nb ? -b : b;
    end else if (state == MD_BUSY) begin
      cnt <= cnt + CW'(1);
      hi  <= hi_n;
      lo  <= lo_n;
      if (last) result <= fix;
    end
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: ID/EX register, forwarding, ALU, branch resolution
// and the iterative mul/div unit.
module ex_stage_mdu
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  ex_stage_mdu_if.slave   id,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  output ex_ctrl_t        CtrlE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE,
  output logic            MdBusyE
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE;
  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b;
  logic [XLEN-1:0] alu, md_res, tgt;
  logic [SW-1:0]   sh;
  logic            md_done, taken;

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      CtrlE    <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      ImmExtE  <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else if (!(StallE || MdBusyE)) begin
      CtrlE    <= id.CtrlD;
      RD1E     <= id.RD1D;
      RD2E     <= id.RD2D;
      PCE      <= id.PCD;
      PCPlus4E <= id.PCPlus4D;
      ImmExtE  <= id.ImmExtD;
      Rs1E     <= id.Rs1D;
      Rs2E     <= id.Rs2D;
      RdE      <= id.RdD;
    end
  end

  always_comb begin
    case (ForwardAE)
      FWD_W:   fwd_a = ResultW;
      FWD_M:   fwd_a = ALUResultM;
      default: fwd_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_W:   fwd_b = ResultW;
      FWD_M:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_a      = CtrlE.SrcAsrc ? PCE : fwd_a;
  assign src_b      = CtrlE.ALUSrc ? ImmExtE : fwd_b;
  assign sh         = src_b[SW-1:0];
  assign WriteDataE = fwd_b;

  always_comb begin
    case (CtrlE.ALUControl)
      ALU_ADD:   alu = src_a + src_b;
      ALU_SUB:   alu = src_a - src_b;
      ALU_AND:   alu = src_a & src_b;
      ALU_OR:    alu = src_a | src_b;
      ALU_XOR:   alu = src_a ^ src_b;
      ALU_SLT:   alu = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLTU:  alu = XLEN'(src_a < src_b);
      ALU_SLL:   alu = src_a << sh;
      ALU_SRL:   alu = src_a >> sh;
      ALU_SRA:   alu = XLEN'($signed(src_a) >>> sh);
      ALU_PASSB: alu = src_b;
      default:   alu = '0;
    endcase
  end

  always_comb begin
    case (CtrlE.funct3)
      F3_BEQ:  taken = fwd_a == fwd_b;
      F3_BNE:  taken = fwd_a != fwd_b;
      F3_BLT:  taken = $signed(fwd_a) < $signed(fwd_b);
      F3_BGE:  taken = $signed(fwd_a) >= $signed(fwd_b);
      F3_BLTU: taken = fwd_a < fwd_b;
      F3_BGEU: taken = fwd_a >= fwd_b;
      default: taken = 1'b0;
    endcase
  end

  assign PCSrcE    = (CtrlE.Branch & taken) | CtrlE.Jump;
  assign tgt       = (CtrlE.jumpReg ? fwd_a : PCE) + ImmExtE;
  assign PCTargetE = {tgt[XLEN-1:1], tgt[0] & ~CtrlE.jumpReg};

  mdu_iter #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .flush  (FlushE),
    .start  (CtrlE.MulDiv),
    .hold   (StallE),
    .op     (md_op_e'(CtrlE.funct3)),
    .a      (fwd_a),
    .b      (fwd_b),
    .done   (md_done),
    .result (md_res)
  );

  assign MdBusyE    = CtrlE.MulDiv & ~md_done;
  assign ALUResultE = CtrlE.MulDiv ? md_res : alu;

endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu
Parametrised execute stage: ID/EX pipeline register with stall/flush, operand forwarding, ALU, branch/jump resolution, and an iterative multiply/divide unit implementing RV M-extension ops. Sits between decode and memory stages. Asserts `MdBusyE` to the hazard unit while a mul/div occupies EX.
## Interface
- `XLEN`, 32: datapath width.
- `BPC`, 1: mul/div bits retired per cycle; must divide XLEN (1, 2 or 4). N = XLEN/BPC.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `StallE` in 1: hold the EX register.
- `FlushE` in 1: load a bubble into EX and abort any mul/div.
- `CtrlD` in `ex_ctrl_t`: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[3:0], ALUSrc, SrcAsrc, funct3[2:0], jumpReg, MulDiv.
- `RD1D` in XLEN: rs1 register read.
- `RD2D` in XLEN: rs2 register read.
- `PCD` in XLEN: instruction PC.
- `PCPlus4D` in XLEN: PC+4.
- `ImmExtD` in XLEN: extended immediate.
- `Rs1D` in 5: rs1 index.
- `Rs2D` in 5: rs2 index.
- `RdD` in 5: rd index.
- `ResultW` in XLEN: writeback forward value.
- `ALUResultM` in XLEN: memory-stage forward value.
- `ForwardAE` in 2: rs1 select: 00 reg, 01 ResultW, 10 ALUResultM.
- `ForwardBE` in 2: rs2 select, same encoding.
- `CtrlE` out `ex_ctrl_t`: registered control.
- `Rs1E` out 5: registered rs1 index.
- `Rs2E` out 5: registered rs2 index.
- `RdE` out 5: registered rd index.
- `PCPlus4E` out XLEN: registered PC+4.
- `ALUResultE` out XLEN: ALU result, or mul/div result when `CtrlE.MulDiv`.
- `WriteDataE` out XLEN: forwarded rs2, the store data.
- `PCTargetE` out XLEN: branch/jump target.
- `PCSrcE` out 1: redirect fetch.
- `MdBusyE` out 1: mul/div stall request.
## Operation
- EX register priority is reset > FlushE > (StallE | MdBusyE) hold > load. Reset and flush zero every field, giving a bubble with all control 0 and RegWrite 0. Reset values: all outputs 0; FSM in IDLE.
- Operands:
  - SrcA = SrcAsrc ? PCE : fwdA.
  - WriteDataE = fwdB.
  - SrcB = ALUSrc ? ImmExtE : fwdB.
  - ALU op uses the existing `alu_op_t` encoding.
- Branch compare uses fwdA vs fwdB by funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. PCSrcE = (Branch & taken) | Jump.
- Jump target: PCTargetE = (jumpReg ? fwdA : PCE) + ImmExtE. For jumpReg (JALR), bit 0 is forced to 0.
- MulDiv ops by funct3: MUL 000, MULH 001 (s×s), MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
  - Signed ops run on magnitudes; sign is fixed up on entry to DONE.
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0.
  - Special cases still take full latency.
## Timing
- FSM IDLE → BUSY → DONE → IDLE.
  - IDLE with `CtrlE.MulDiv`: capture fwdA/fwdB into MDU, clear counter, go BUSY.
  - BUSY: N iterations, then DONE.
  - DONE: result is on ALUResultE; stays in DONE while StallE, else returns to IDLE as the next instruction loads.
- MdBusyE = CtrlE.MulDiv & state≠DONE, combinational. It is high for N+1 cycles, so EX occupancy is N+2 cycles. Forwarded values may change after capture without effect.
- FlushE in any state returns to IDLE next edge, with the result discarded. Reset mid-operation does the same.
- Non-MulDiv instructions have 0 added latency; PCSrcE and PCTargetE are combinational from EX register contents.
## Structure
- `rv_pkg` holds `ex_ctrl_t`, `alu_op_t`, `md_op_e` (funct3 encodings), the forward-select constants, and the MDU state enum. The package is shared with decode and the hazard unit.
- One sub-module, `mdu_iter` (parametrised XLEN, BPC), holds the shift-add multiplier, restoring divider, counter and FSM. The top holds the register, forwarding muxes, ALU and branch logic.
## Test plan
- Reset, then ADD with RD1D=5, RD2D=7: ALUResultE=12 one cycle after load; all outputs 0 during reset.
- MUL, XLEN=32, BPC=1, rs1=−3, rs2=7 (MULH): MdBusyE high 33 cycles; ALUResultE=0xFFFFFFFF in DONE. MUL gives 0xFFFFFFEB.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9. Each has the same fixed latency.
- FlushE at BUSY cycle 10: next cycle state IDLE, MdBusyE=0, CtrlE zeroed. A following MUL 6×7 returns 42.
- BLT with ForwardAE=10, ALUResultM=−1, RD2D=0: PCSrcE=1. JALR with fwdA=0x101, imm=4: PCTargetE=0x104.
